// File: rtl/seq_gen_pkg.sv
// seq_gen_pkg: shared types and constants for the serial pattern transmitter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//   state_e         : transmitter FSM state, 3-bit encoding
//   DEFAULT_PATTERN : reference 4-bit pattern (1011) used by callers and benches
package seq_gen_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SHIFT = 3'd1,
        GAP   = 3'd2,
        DONE  = 3'd3
    } state_e;

    localparam logic [3:0] DEFAULT_PATTERN = 4'b1011;

endpackage : seq_gen_pkg

// File: rtl/seq_gen_shreg.sv
// seq_gen_shreg: MSB-first pattern shift register with a bit-position index.
// Latency: load/shift take effect on the next rising clk edge; msb/empty are
//          combinational from the registered state.
// Backpressure: none internally; the caller only pulses shift on an accepted transfer.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   load       : capture pattern, index restarts at the MSB (wins over shift)
//   shift      : advance to the next lower bit
//   pattern    : value captured on load
//   msb        : bit currently presented
//   empty      : presented bit is bit 0, i.e. nothing remains behind it
module seq_gen_shreg #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] pattern,
    output logic         msb,
    output logic         empty
);

    // Keep the index at least one bit wide so W = 1 still elaborates.
    localparam int IDX_W = (W > 1) ? $clog2(W) : 1;

    logic [W-1:0]     sr_q, sr_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    always_comb begin
        sr_d  = sr_q;
        idx_d = idx_q;
        if (load) begin
            sr_d  = pattern;
            idx_d = IDX_W'(W - 1);
        end else if (shift) begin
            sr_d  = sr_q << 1;
            idx_d = idx_q - IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q  <= '0;
            idx_q <= '0;
        end else begin
            sr_q  <= sr_d;
            idx_q <= idx_d;
        end
    end

    assign msb   = sr_q[W-1];
    // idx counts the bits still to come after the presented one.
    assign empty = (idx_q == '0);

endmodule : seq_gen_shreg

// File: rtl/seq_gen_tx.sv
// seq_gen_tx: serialises a latched pattern MSB first, repeat_cnt times, valid/ready out.
// Latency: first bit valid the cycle after start is accepted; done one cycle after last transfer.
// Backpressure: out_ready low freezes outbit, last and all state until the bit is taken.
// Build option: define SEQ_GEN_GAP_EN to insert one idle (GAP) cycle between repetitions;
//               without it repetitions go back-to-back and GAP is never entered.
// Ports:
//   clk, reset        : clock, synchronous active-high reset (wins over start)
//   start             : transmission request, only honoured in IDLE
//   pattern_in        : pattern, sampled when start is accepted
//   repeat_cnt        : number of repetitions, sampled when start is accepted
//   outbit, out_valid : serial data and its qualifier
//   out_ready         : downstream accept
//   last              : bit 0 of the final repetition is being presented
//   busy              : FSM not in IDLE
//   done              : one-cycle completion pulse
module seq_gen_tx
    import seq_gen_pkg::*;
#(
    parameter int PATTERN_W = 4,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [PATTERN_W-1:0] pattern_in,
    input  logic [CNT_W-1:0]     repeat_cnt,
    output logic                 outbit,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 last,
    output logic                 busy,
    output logic                 done
);

    state_e               state_q, state_d;
    logic [PATTERN_W-1:0] pattern_q, pattern_d;
    // Repetitions still to send, including the one in flight.
    logic [CNT_W-1:0]     rep_q, rep_d;

    logic                 sh_load;
    logic                 sh_shift;
    logic [PATTERN_W-1:0] sh_pattern;
    logic                 sh_msb;
    logic                 sh_empty;
    logic                 final_rep;

    assign final_rep = (rep_q == CNT_W'(1));

    seq_gen_shreg #(
        .W (PATTERN_W)
    ) u_shreg (
        .clk     (clk),
        .reset   (reset),
        .load    (sh_load),
        .shift   (sh_shift),
        .pattern (sh_pattern),
        .msb     (sh_msb),
        .empty   (sh_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            pattern_q <= '0;
            rep_q     <= '0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            rep_q     <= rep_d;
        end
    end

    // All outputs derive from registered state only, so reset reaches them
    // solely through the state register.
    always_comb begin
        state_d    = state_q;
        pattern_d  = pattern_q;
        rep_d      = rep_q;
        sh_load    = 1'b0;
        sh_shift   = 1'b0;
        sh_pattern = pattern_q;
        out_valid  = 1'b0;
        outbit     = 1'b0;
        last       = 1'b0;
        done       = 1'b0;
        busy       = (state_q != IDLE);

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    pattern_d = pattern_in;
                    rep_d     = repeat_cnt;
                    if (repeat_cnt == '0) begin
                        // Nothing to send: finish without ever raising out_valid.
                        state_d = DONE;
                    end else begin
                        // Load from the port directly so the MSB is presented next cycle.
                        sh_load    = 1'b1;
                        sh_pattern = pattern_in;
                        state_d    = SHIFT;
                    end
                end
            end

            SHIFT: begin
                out_valid = 1'b1;
                outbit    = sh_msb;
                last      = sh_empty && final_rep;
                if (out_ready) begin
                    if (!sh_empty) begin
                        sh_shift = 1'b1;
                    end else if (final_rep) begin
                        state_d = DONE;
                    end else begin
                        // Reload now; with the gap enabled the MSB simply waits
                        // in the register through the GAP cycle.
                        rep_d   = rep_q - CNT_W'(1);
                        sh_load = 1'b1;
`ifdef SEQ_GEN_GAP_EN
                        state_d = GAP;
`endif
                    end
                end
            end

            GAP: begin
`ifdef SEQ_GEN_GAP_EN
                state_d = SHIFT;
`else
                state_d = IDLE;
`endif
            end

            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule : seq_gen_tx
